// File: rtl/wb_pipe_reg.sv
// Multi-lane write-back pipeline register with stall/flush and a bypass lookup
// that returns the youngest in-flight write to a given register address.
module wb_pipe_reg #(
  parameter int LANES  = 2,
  parameter int DEPTH  = 1,
  parameter int ADRS_W = 4,
  parameter int DATA_W = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       stall,
  input  logic                       flush,
  input  logic [LANES-1:0]           in_wr_en,
  input  logic [LANES*ADRS_W-1:0]    in_dst,
  input  logic [LANES*DATA_W-1:0]    in_data,
  input  logic [LANES-1:0]           in_datav,
  output logic [LANES-1:0]           out_wr_en,
  output logic [LANES*ADRS_W-1:0]    out_dst,
  output logic [LANES*DATA_W-1:0]    out_data,
  output logic [LANES-1:0]           out_datav,
  input  logic [ADRS_W-1:0]          lkp_adrs,
  output logic                       lkp_hit,
  output logic [DATA_W-1:0]          lkp_data,
  output logic                       lkp_datav
);

  logic [LANES-1:0]        wr_en_q [DEPTH];
  logic [LANES*ADRS_W-1:0] dst_q   [DEPTH];
  logic [LANES*DATA_W-1:0] data_q  [DEPTH];
  logic [LANES-1:0]        datav_q [DEPTH];

  logic [LANES-1:0]        wr_en_d [DEPTH];
  logic [LANES*ADRS_W-1:0] dst_d   [DEPTH];
  logic [LANES*DATA_W-1:0] data_d  [DEPTH];
  logic [LANES-1:0]        datav_d [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [LANES-1:0]        src_wr_en;
      logic [LANES*ADRS_W-1:0] src_dst;
      logic [LANES*DATA_W-1:0] src_data;
      logic [LANES-1:0]        src_datav;

      if (gi == 0) begin : g_head
        assign src_wr_en = in_wr_en;
        assign src_dst   = in_dst;
        assign src_data  = in_data;
        assign src_datav = in_datav;
      end else begin : g_body
        assign src_wr_en = wr_en_q[gi-1];
        assign src_dst   = dst_q[gi-1];
        assign src_data  = data_q[gi-1];
        assign src_datav = datav_q[gi-1];
      end

      // reset and flush both clear every field; stall only holds
      always_comb begin
        wr_en_d[gi] = wr_en_q[gi];
        dst_d[gi]   = dst_q[gi];
        data_d[gi]  = data_q[gi];
        datav_d[gi] = datav_q[gi];
        if (reset || flush) begin
          wr_en_d[gi] = '0;
          dst_d[gi]   = '0;
          data_d[gi]  = '0;
          datav_d[gi] = '0;
        end else if (!stall) begin
          wr_en_d[gi] = src_wr_en;
          dst_d[gi]   = src_dst;
          data_d[gi]  = src_data;
          datav_d[gi] = src_datav;
        end
      end

      always_ff @(posedge clock) begin
        wr_en_q[gi] <= wr_en_d[gi];
        dst_q[gi]   <= dst_d[gi];
        data_q[gi]  <= data_d[gi];
        datav_q[gi] <= datav_d[gi];
      end
    end
  endgenerate

  assign out_wr_en = wr_en_q[DEPTH-1];
  assign out_dst   = dst_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign out_datav = datav_q[DEPTH-1];

  // Scan oldest-to-youngest, low-to-high lane, so the last match written is the winner.
  always_comb begin
    lkp_hit   = 1'b0;
    lkp_data  = '0;
    lkp_datav = 1'b0;
    for (int s = DEPTH - 1; s >= 0; s--) begin
      for (int l = 0; l < LANES; l++) begin
        if (wr_en_q[s][l] && (dst_q[s][l*ADRS_W +: ADRS_W] == lkp_adrs)) begin
          lkp_hit   = 1'b1;
          lkp_data  = data_q[s][l*DATA_W +: DATA_W];
          lkp_datav = datav_q[s][l];
        end
      end
    end
    if (reset || (lkp_adrs == '0)) begin
      lkp_hit   = 1'b0;
      lkp_data  = '0;
      lkp_datav = 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_pipe_reg.sv
// Scoreboard bench for wb_pipe_reg: a queue-based pipeline model predicts out_* and
// lookup results per cycle; a monitor on the falling edge pops and compares.
module tb_wb_pipe_reg;
  localparam int LANES  = 2;
  localparam int DEPTH  = 3;
  localparam int ADRS_W = 4;
  localparam int DATA_W = 16;

  logic                    clock = 1'b0;
  logic                    reset, stall, flush;
  logic [LANES-1:0]        in_wr_en, in_datav, out_wr_en, out_datav;
  logic [LANES*ADRS_W-1:0] in_dst, out_dst;
  logic [LANES*DATA_W-1:0] in_data, out_data;
  logic [ADRS_W-1:0]       lkp_adrs;
  logic                    lkp_hit, lkp_datav;
  logic [DATA_W-1:0]       lkp_data;

  wb_pipe_reg #(.LANES(LANES), .DEPTH(DEPTH), .ADRS_W(ADRS_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush),
    .in_wr_en(in_wr_en), .in_dst(in_dst), .in_data(in_data), .in_datav(in_datav),
    .out_wr_en(out_wr_en), .out_dst(out_dst), .out_data(out_data), .out_datav(out_datav),
    .lkp_adrs(lkp_adrs), .lkp_hit(lkp_hit), .lkp_data(lkp_data), .lkp_datav(lkp_datav)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [LANES-1:0]        we;
    logic [LANES*ADRS_W-1:0] dst;
    logic [LANES*DATA_W-1:0] data;
    logic [LANES-1:0]        dv;
  } ent_t;

  typedef struct packed {
    ent_t              out;
    logic              hit;
    logic [DATA_W-1:0] ldata;
    logic              ldv;
  } exp_t;

  ent_t pipe[$];     // index 0 = youngest stage
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
    end
  endtask

  // Youngest stage first, highest lane first within a stage; register 0 never hits.
  task automatic model_lookup(input logic [ADRS_W-1:0] a, output logic hit,
                              output logic [DATA_W-1:0] d, output logic dv);
    ent_t e;
    hit = 1'b0; d = '0; dv = 1'b0;
    if (a != 0) begin
      for (int s = 0; s < DEPTH && !hit; s++) begin
        e = pipe[s];
        for (int l = LANES - 1; l >= 0 && !hit; l--) begin
          if (e.we[l] && e.dst[l*ADRS_W +: ADRS_W] == a) begin
            hit = 1'b1;
            d   = e.data[l*DATA_W +: DATA_W];
            dv  = e.dv[l];
          end
        end
      end
    end
  endtask

  // Called just after a falling edge: drives one cycle, predicts the state after the next rising edge.
  task automatic cyc(input logic r, input logic f, input logic s, input ent_t in_e,
                     input logic [ADRS_W-1:0] la);
    exp_t x;
    ent_t drop;
    reset = r; flush = f; stall = s;
    in_wr_en = in_e.we; in_dst = in_e.dst; in_data = in_e.data; in_datav = in_e.dv;
    lkp_adrs = la;
    if (r || f) begin
      foreach (pipe[i]) pipe[i] = '0;
    end else if (!s) begin
      pipe.push_front(in_e);
      drop = pipe.pop_back();
    end
    x.out = pipe[DEPTH-1];
    model_lookup(la, x.hit, x.ldata, x.ldv);
    if (r) begin
      x.hit = 1'b0; x.ldata = '0; x.ldv = 1'b0;
    end
    sb.push_back(x);
    @(negedge clock); #1;
  endtask

  function automatic ent_t mk(input logic [LANES-1:0] we, input logic [3:0] d0, input logic [15:0] v0,
                              input logic [3:0] d1, input logic [15:0] v1, input logic [LANES-1:0] dv);
    ent_t e;
    e.we = we; e.dv = dv;
    e.dst  = {d1, d0};
    e.data = {v1, v0};
    return e;
  endfunction

  function automatic ent_t rnd_ent();
    ent_t e;
    e.we = LANES'($urandom);
    e.dv = LANES'($urandom);
    for (int l = 0; l < LANES; l++) begin
      e.dst[l*ADRS_W +: ADRS_W]  = ADRS_W'($urandom_range(0, 7));
      e.data[l*DATA_W +: DATA_W] = DATA_W'($urandom);
    end
    return e;
  endfunction

  // Monitor: the DUT presents a bundle every cycle; compare it against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_wr_en", 64'(out_wr_en), 64'(e.out.we));
        chk("out_dst",   64'(out_dst),   64'(e.out.dst));
        chk("out_data",  64'(out_data),  64'(e.out.data));
        chk("out_datav", 64'(out_datav), 64'(e.out.dv));
        chk("lkp_hit",   64'(lkp_hit),   64'(e.hit));
        chk("lkp_data",  64'(lkp_data),  64'(e.ldata));
        chk("lkp_datav", 64'(lkp_datav), 64'(e.ldv));
        $display("[TB] t=%0t out_we=%b out_dst=%h out_data=%h lkp=%0d hit=%b data=%h dv=%b",
                 $time, out_wr_en, out_dst, out_data, lkp_adrs, lkp_hit, lkp_data, lkp_datav);
      end
    end
  end

  initial begin
    ent_t z;
    z = '0;
    for (int i = 0; i < DEPTH; i++) pipe.push_back('0);
    reset = 1'b1; stall = 1'b0; flush = 1'b0;
    in_wr_en = '0; in_dst = '0; in_data = '0; in_datav = '0; lkp_adrs = '0;
    @(negedge clock); #1;

    cyc(1, 0, 0, z, 4'd0);
    cyc(1, 0, 0, z, 4'd3);
    // single entry travels DEPTH cycles, zeros ahead of it
    cyc(0, 0, 0, mk(2'b01, 4'd3, 16'h00AA, 4'd0, 16'h0000, 2'b01), 4'd3);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, z, 4'd3);
    // entry then three stall cycles
    cyc(0, 0, 0, mk(2'b11, 4'd4, 16'h1234, 4'd6, 16'h5678, 2'b11), 4'd6);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, rnd_ent(), 4'd4);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, z, 4'd4);
    // fill, then flush together with stall
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, mk(2'b11, 4'd2, 16'hBEEF, 4'd2, 16'hCAFE, 2'b11), 4'd2);
    cyc(0, 1, 1, rnd_ent(), 4'd2);
    for (int a = 1; a < 8; a++) cyc(0, 0, 1, z, ADRS_W'(a));
    // youngest stage beats older stage
    cyc(0, 0, 0, mk(2'b01, 4'd5, 16'h2222, 4'd1, 16'h0000, 2'b01), 4'd5);
    cyc(0, 0, 0, mk(2'b10, 4'd5, 16'h0000, 4'd5, 16'h1111, 2'b10), 4'd5);
    // higher lane beats lower lane
    cyc(0, 0, 0, mk(2'b11, 4'd7, 16'h0001, 4'd7, 16'h0002, 2'b11), 4'd7);
    // register 0 never hits
    cyc(0, 0, 0, mk(2'b01, 4'd0, 16'h0F0F, 4'd0, 16'h0000, 2'b01), 4'd0);
    // hit on an entry whose data is not yet valid
    cyc(0, 0, 0, mk(2'b01, 4'd9, 16'h3333, 4'd0, 16'h0000, 2'b00), 4'd9);
    cyc(0, 0, 1, z, 4'd9);
    // reset pulse with entries in flight
    cyc(0, 0, 0, mk(2'b11, 4'd8, 16'h4444, 4'd10, 16'h5555, 2'b11), 4'd8);
    cyc(0, 0, 0, mk(2'b11, 4'd11, 16'h6666, 4'd12, 16'h7777, 2'b11), 4'd11);
    cyc(1, 0, 0, rnd_ent(), 4'd8);
    for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 0, z, 4'd11);
    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      logic r, f, s;
      r = ($urandom_range(0, 99) < 2);
      f = ($urandom_range(0, 99) < 5);
      s = ($urandom_range(0, 99) < 20);
      cyc(r, f, s, rnd_ent(), ADRS_W'($urandom_range(0, 7)));
    end
    @(negedge clock); #1;
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
